uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Receive side of the board UART: recovers 8N1 frames from the serial rx line at BAUD_RATE.
//   Uses 16x oversampling, samples each bit at mid-bit and presents a parallel byte.
//   Each received byte comes with a one-cycle valid strobe; framing errors are flagged.
//   Sits between the FPGA rx pin and the user logic; pairs with the existing UART transmitter.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency, Hz
//   BAUD_RATE   9600         line rate, bits/s
//   OVERSAMPLE  16           sample ticks per bit; must be even and >= 8
//   DATA_BITS   8            payload bits per frame; LSB first
// PORTS
//   clk         in   1          system clock; all logic on posedge
//   rst         in   1          synchronous, active-high reset
//   rx          in   1          asynchronous serial input; idles high
//   rx_data     out  DATA_BITS  last good byte; held until the next good frame
//   rx_valid    out  1          1-clk pulse: rx_data is newly updated
//   frame_err   out  1          1-clk pulse: stop bit sampled low
//   busy        out  1          high in any state other than IDLE
// BEHAVIOUR
//   - Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE.
//     Synchronizer flops reset to 1. rst mid-frame aborts the frame with no strobe.
//   - Sync: rx passes through 2 flops (rx_s) before any use; adds 2 clk of latency.
//   - Tick: TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated (651 at defaults).
//     tick is a 1-clk pulse each TICK_DIV clocks. The tick counter is cleared on the start edge.
//   - FSM: IDLE -> START -> DATA -> STOP, plus WAIT_IDLE.
//   - IDLE: a 1->0 transition on rx_s clears the tick counter and sample count, then goes to START.
//   - START: at tick count OVERSAMPLE/2-1 (mid-bit), sample rx_s.
//     If rx_s=1, this is a glitch: return to IDLE with no strobe.
//     If rx_s=0, reset the tick count and go to DATA.
//   - DATA: every OVERSAMPLE ticks (mid-bit), shift rx_s into the MSB of the shift register.
//     The shift is right, so bits arrive LSB first. After DATA_BITS samples, go to STOP.
//   - STOP: sample at mid-bit.
//     If 1: rx_data<=shift, rx_valid=1 for one clk, go to IDLE.
//     If 0: frame_err=1 for one clk, rx_data unchanged, go to WAIT_IDLE.
//   - WAIT_IDLE: stay until rx_s=1, then go to IDLE. A break condition therefore raises exactly one error.
//   - Strobe timing: the strobe is registered on the clk after the mid-stop sample tick.
//     rx_valid and frame_err are never high together.
//   - Next frame: detection is re-armed immediately after STOP. Back-to-back frames with a
//     single stop bit must be received.
//   - Counters: tick counter width is $clog2(TICK_DIV). Bit counter width is $clog2(DATA_BITS+1).
//     No counter wraps; each is explicitly cleared.
// STRUCTURE
//   - Shared include uart_defs.vh holds:
//     - state encodings (IDLE, START, DATA, STOP, WAIT_IDLE);
//     - default CLK_FREQ and BAUD_RATE;
//     - the TICK_DIV expression.
//   - The TX and RX sides use this include together.
//   - Sub-module uart_rx_tick_gen (params CLK_FREQ, BAUD_RATE, OVERSAMPLE; ports clk, rst,
//     clear, tick) is the oversample divider.
//   - Synchronizer, FSM, shift register and output registers stay in uart_rx.
// TESTING
//   Defaults throughout; bit period = 651*16 = 10416 clk.
//   1. Send 0xA5, 8N1, at the exact bit period
//      -> one rx_valid pulse, rx_data=8'hA5, frame_err never high.
//   2. Send 0x00, 0xFF, 0x55 back-to-back, no idle gap
//      -> three rx_valid pulses in order with those values, spaced 10 bit periods apart.
//   3. Pulse rx low for 3000 clk (< half bit) from idle
//      -> returns to IDLE, no rx_valid/frame_err, busy falls, rx_data unchanged.
//   4. Send 0x3C with stop bit forced 0, then hold rx low for 20 bit periods
//      -> exactly one frame_err pulse, no rx_valid, rx_data keeps its old value.
//      After rx returns high, 0x81 is then received correctly.
//   5. Assert rst for 1 clk in the middle of data bit 4 of a frame
//      -> outputs equal their reset values, no strobe for that frame; the next full frame 0x42 is received.
//   6. Send 0xC3 with the bit period skewed +/-3% (10104 and 10728 clk)
//      -> rx_data=8'hC3 with rx_valid in both cases.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ============================================================================
// uart_rx_pkg : shared UART defaults, receiver state encoding, divider maths
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

   localparam int DEF_CLK_FREQ   = 100_000_000;
   localparam int DEF_BAUD_RATE  = 9600;
   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_e;

   // Integer-truncated clocks per oversample tick; both UART sides share it.
   function automatic int tick_div(input int clk_freq, input int baud_rate,
                                   input int oversample);
      return clk_freq / (baud_rate * oversample);
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
// ============================================================================
// uart_rx_tick_gen : oversample divider, one-clk tick every TICK_DIV clocks
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_tick_gen
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int BAUD_RATE  = DEF_BAUD_RATE,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int CNT_W    = cnt_width(TICK_DIV);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == TICK_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A clear restarts the bit timing, so a tick coinciding with it is dropped.
   assign tick = (cnt_q == TICK_LAST) && !clear;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver, 16x oversampled mid-bit sampling, framing check
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int BAUD_RATE  = DEF_BAUD_RATE,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int DATA_BITS  = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int OS_W  = cnt_width(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [OS_W-1:0]  MID_TICK  = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  LAST_TICK = OS_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   rx_state_e state_d, state_q;

   logic                 rx_meta_d, rx_meta_q;
   logic                 rx_s_d,    rx_s_q;
   logic                 rx_prev_d, rx_prev_q;
   logic [OS_W-1:0]      os_cnt_d,  os_cnt_q;
   logic [BIT_W-1:0]     bit_cnt_d, bit_cnt_q;
   logic [DATA_BITS-1:0] shift_d,   shift_q;
   logic [DATA_BITS:0]   shift_ext;
   logic [DATA_BITS-1:0] rx_data_d, rx_data_q;
   logic                 rx_valid_d, rx_valid_q;
   logic                 frame_err_d, frame_err_q;
   logic                 tick_clear;
   logic                 tick;

   uart_rx_tick_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clear),
      .tick  (tick)
   );

   // Right shift with the new sample entering at the MSB gives LSB-first order.
   assign shift_ext = {rx_s_q, shift_q};

   always_comb begin
      state_d     = state_q;
      rx_meta_d   = rx;
      rx_s_d      = rx_meta_q;
      rx_prev_d   = rx_s_q;
      os_cnt_d    = os_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      tick_clear  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rx_prev_q && !rx_s_q) begin
               tick_clear = 1'b1;
               os_cnt_d   = '0;
               bit_cnt_d  = '0;
               state_d    = START;
            end
         end

         START: begin
            if (tick) begin
               if (os_cnt_q == MID_TICK) begin
                  os_cnt_d = '0;
                  state_d  = rx_s_q ? IDLE : DATA;
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end

         DATA: begin
            if (tick) begin
               if (os_cnt_q == LAST_TICK) begin
                  os_cnt_d  = '0;
                  shift_d   = shift_ext[DATA_BITS:1];
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = STOP;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end

         STOP: begin
            if (tick) begin
               if (os_cnt_q == LAST_TICK) begin
                  os_cnt_d = '0;
                  if (rx_s_q) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = WAIT_IDLE;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + 1'b1;
               end
            end
         end

         // Holding here until the line recovers makes a break report only once.
         WAIT_IDLE: begin
            if (rx_s_q) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_prev_q   <= 1'b1;
         os_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         rx_prev_q   <= rx_prev_d;
         os_cnt_q    <= os_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed + randomized frames checked against a frame-level model
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

   // Scaled clock keeps the run short: 1.65 MHz / (10 kbaud * 16) truncates to 10.
   localparam int CLK_FREQ   = 1_650_000;
   localparam int BAUD_RATE  = 10_000;
   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int BIT_CLKS   = (CLK_FREQ / (BAUD_RATE * OVERSAMPLE)) * OVERSAMPLE;
   localparam int BIT_FAST   = (BIT_CLKS * 97) / 100;
   localparam int BIT_SLOW   = (BIT_CLKS * 103 + 50) / 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   uart_rx #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (OVERSAMPLE),
      .DATA_BITS  (DATA_BITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed strobes
   logic [7:0] got_data[$];
   longint     got_time[$];
   int         err_cnt  = 0;
   int         both_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            got_data.push_back(rx_data);
            got_time.push_back(cyc);
         end
         if (frame_err) err_cnt++;
         if (rx_valid && frame_err) both_cnt++;
      end
   end

   // Frame-level reference: good stop -> byte delivered, bad stop -> one error
   logic [7:0] exp_q[$];
   int         exp_err  = 0;
   logic [7:0] exp_last = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop, input int bp);
      drive(1'b0, bp);
      for (int i = 0; i < 8; i++) drive(b[i], bp);
      drive(stop, bp);
      if (stop) begin
         exp_q.push_back(b);
         exp_last = b;
      end else begin
         exp_err++;
      end
   endtask

   task automatic verify(input string tag);
      check({tag, "_count"}, got_data.size(), exp_q.size());
      while (exp_q.size() > 0 && got_data.size() > 0) begin
         check({tag, "_data"}, got_data.pop_front(), exp_q.pop_front());
      end
      got_data.delete();
      got_time.delete();
      exp_q.delete();
      check({tag, "_frame_err"}, err_cnt, exp_err);
      check({tag, "_rx_data"}, rx_data, exp_last);
      check({tag, "_overlap"}, both_cnt, 0);
   endtask

   initial begin
      #800_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int         n;

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      drive(1'b1, 20);

      // Single frame
      send(8'hA5, 1'b1, BIT_CLKS);
      drive(1'b1, 2 * BIT_CLKS);
      verify("t1");

      // Back-to-back frames, one stop bit each
      send(8'h00, 1'b1, BIT_CLKS);
      send(8'hFF, 1'b1, BIT_CLKS);
      send(8'h55, 1'b1, BIT_CLKS);
      drive(1'b1, 2 * BIT_CLKS);
      if (got_time.size() >= 3) begin
         check("t2_gap01", 32'(got_time[1] - got_time[0]), 10 * BIT_CLKS);
         check("t2_gap12", 32'(got_time[2] - got_time[1]), 10 * BIT_CLKS);
      end
      verify("t2");

      // Short glitch shorter than half a bit
      drive(1'b0, (BIT_CLKS * 3000) / 10416);
      rx = 1'b1;
      check("t3_busy_rise", busy, 1);
      n = 0;
      while (busy && n < 2 * BIT_CLKS) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t3_busy_fall", busy, 0);
      drive(1'b1, BIT_CLKS);
      verify("t3");

      // Bad stop bit followed by a long break
      send(8'h3C, 1'b0, BIT_CLKS);
      drive(1'b0, 20 * BIT_CLKS);
      check("t4_busy_break", busy, 1);
      drive(1'b1, 2 * BIT_CLKS);
      check("t4_busy_idle", busy, 0);
      verify("t4_err");
      send(8'h81, 1'b1, BIT_CLKS);
      drive(1'b1, 2 * BIT_CLKS);
      verify("t4");

      // Reset in the middle of data bit 4; upper nibble high so no false start follows
      b = 8'hF0 | 8'($urandom_range(0, 15));
      drive(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) drive(b[i], BIT_CLKS);
      drive(1'b1, BIT_CLKS / 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_last = 8'h00;
      check("t5_rst_rx_data", rx_data, 0);
      check("t5_rst_rx_valid", rx_valid, 0);
      check("t5_rst_frame_err", frame_err, 0);
      check("t5_rst_busy", busy, 0);
      drive(1'b1, 5 * BIT_CLKS);
      verify("t5_abort");
      send(8'h42, 1'b1, BIT_CLKS);
      drive(1'b1, 2 * BIT_CLKS);
      verify("t5");

      // Baud skew of about -3% and +3%
      send(8'hC3, 1'b1, BIT_FAST);
      drive(1'b1, 2 * BIT_CLKS);
      verify("t6_fast");
      send(8'hC3, 1'b1, BIT_SLOW);
      drive(1'b1, 2 * BIT_CLKS);
      verify("t6_slow");

      // Random bytes with random idle gaps
      for (int k = 0; k < 6; k++) begin
         b = 8'($urandom_range(0, 255));
         send(b, 1'b1, BIT_CLKS);
         drive(1'b1, $urandom_range(1, 40));
      end
      drive(1'b1, 2 * BIT_CLKS);
      verify("rnd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
